// File: rtl/fp_norm_pkg.sv
// Shared types and constants for the FP adder normalizer.
// Shift-code constants are sized for the default exponent width.
package fp_norm_pkg;

    localparam int MANT_W_DEF = 24;
    localparam int EXP_W_DEF  = 8;

    localparam logic [EXP_W_DEF:0] ZERO_CODE = 9'h1FF;
    localparam logic [EXP_W_DEF:0] NORM_CODE = 9'h000;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } norm_state_e;

endpackage

// File: rtl/norm_shift_seq.sv
// Iterative one-bit-per-cycle mantissa normalizer feeding exponent adjust.
// Emits the normalized mantissa plus a signed shift code in val2.
module norm_shift_seq
    import fp_norm_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W:0]   mant_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic              sign_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] mant_out,
    output logic [EXP_W:0]    val2,
    output logic [EXP_W-1:0]  exp_out,
    output logic              sign_out
);

    norm_state_e       state_q, state_d;
    logic [MANT_W:0]   work_q, work_d;
    logic [EXP_W-1:0]  cnt_q, cnt_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic [EXP_W:0]    val2_q, val2_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              sign_q, sign_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            mant_q  <= '0;
            val2_q  <= '0;
            exp_q   <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            mant_q  <= mant_d;
            val2_q  <= val2_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        mant_d  = mant_q;
        val2_d  = val2_q;
        exp_d   = exp_q;
        sign_d  = sign_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = mant_in;
                    exp_d   = exp_in;
                    sign_d  = sign_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Carry beats zero beats hidden-bit; only then shift left.
                if (work_q[MANT_W]) begin
                    mant_d  = work_q[MANT_W:1];
                    val2_d  = {1'b0, EXP_W'(1)};
                    state_d = DONE;
                end else if (work_q == '0) begin
                    mant_d  = '0;
                    val2_d  = (EXP_W+1)'(ZERO_CODE);
                    state_d = DONE;
                end else if (work_q[MANT_W-1]) begin
                    mant_d  = work_q[MANT_W-1:0];
                    val2_d  = (cnt_q == '0) ? (EXP_W+1)'(NORM_CODE)
                                            : {1'b1, cnt_q};
                    state_d = DONE;
                end else begin
                    work_d = work_q << 1;
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign mant_out  = mant_q;
    assign val2      = val2_q;
    assign exp_out   = exp_q;
    assign sign_out  = sign_q;

endmodule

// File: tb/tb_norm_shift_seq.sv
// Scoreboard bench for norm_shift_seq: directed corner cases then random
// operands, checked against a leading-one reference model.
module tb_norm_shift_seq;

    typedef struct {
        logic [23:0] mant;
        logic [8:0]  val2;
        logic [7:0]  exp;
        logic        sign;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [24:0] mant_in = '0;
    logic [7:0]  exp_in = '0;
    logic        sign_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] mant_out;
    logic [8:0]  val2;
    logic [7:0]  exp_out;
    logic        sign_out;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   last_hs = -100;
    int   hold_n = 0;
    int   ready_cnt = 0;
    bit   seen = 0;
    exp_t sb[$];
    exp_t cur;
    logic [41:0] held;

    norm_shift_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mant_in   (mant_in),
        .exp_in    (exp_in),
        .sign_in   (sign_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mant_out  (mant_out),
        .val2      (val2),
        .exp_out   (exp_out),
        .sign_out  (sign_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Reference: locate the leading one and derive the shift directly.
    function automatic exp_t model(input logic [24:0] m, input logic [7:0] e,
                                   input logic s, input int acc);
        exp_t r;
        int msb;
        int n;
        logic [24:0] sh;
        r.exp  = e;
        r.sign = s;
        n = 0;
        if (m[24]) begin
            r.mant = m[24:1];
            r.val2 = 9'h001;
        end else if (m == 0) begin
            r.mant = '0;
            r.val2 = 9'h1FF;
        end else begin
            msb = 0;
            for (int i = 0; i < 24; i++)
                if (m[i]) msb = i;
            n = 23 - msb;
            sh = m << n;
            r.mant = sh[23:0];
            r.val2 = (n == 0) ? 9'h000 : {1'b1, 8'(n)};
        end
        r.due = acc + 2 + n;
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [24:0] m, input logic [7:0] e,
                        input logic s);
        int  n;
        bit  waited;
        int  acc;
        in_valid = 1'b1;
        mant_in  = m;
        exp_in   = e;
        sign_in  = s;
        n = 0;
        waited = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            waited = 1;
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            acc = cyc + 1;
            sb.push_back(model(m, e, s, acc));
            if (waited) chk("accept_after_release", acc, last_hs + 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        mant_in  = 25'($urandom);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            seen = 0;
            out_ready = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    cur = sb.pop_front();
                    chk("mant_out", mant_out, cur.mant);
                    chk("val2", val2, cur.val2);
                    chk("exp_out", exp_out, cur.exp);
                    chk("sign_out", sign_out, cur.sign);
                    chk("valid_edge", cyc + 1, cur.due);
                end
                held = {mant_out, val2, exp_out, sign_out};
                seen = 1;
                ready_cnt = hold_n;
                hold_n = 0;
            end else begin
                chk("held_stable", 32'({mant_out, val2, exp_out, sign_out}
                    != held), 32'd0);
            end
            chk("in_ready_in_done", in_ready, 1'b0);
            if (ready_cnt > 0) begin
                out_ready = 1'b0;
                ready_cnt--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            if (out_ready) begin
                seen = 0;
                last_hs = cyc + 1;
            end
        end else begin
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [24:0] m;
        int k;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_mant_out", mant_out, 24'h0);
        chk("rst_val2", val2, 9'h0);
        chk("rst_exp_out", exp_out, 8'h0);
        chk("rst_sign_out", sign_out, 1'b0);

        send(25'h0800000, 8'h80, 1'b0);
        send(25'h1000001, 8'h12, 1'b0);
        send(25'h0000001, 8'h40, 1'b1);
        send(25'h0000000, 8'h33, 1'b1);

        // Hold DONE for five cycles while the next operand waits.
        repeat (30) @(negedge clk);
        hold_n = 5;
        send(25'h0123456, 8'h21, 1'b0);
        send(25'h0ABCDEF, 8'h55, 1'b1);
        repeat (40) @(negedge clk);

        // Reset five cycles into a long shift discards the operand.
        send(25'h0000001, 8'h77, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        chk("rst_mid_out_valid", out_valid, 1'b0);
        chk("rst_mid_in_ready", in_ready, 1'b1);
        chk("rst_mid_val2", val2, 9'h0);
        chk("rst_mid_mant", mant_out, 24'h0);
        send(25'h0400000, 8'h90, 1'b0);

        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 9);
            m = 25'($urandom) >> $urandom_range(0, 25);
            if (k == 0) m[24] = 1'b1;
            if (k == 1) m = '0;
            send(m, 8'($urandom), 1'($urandom));
        end

        for (int i = 0; i < 500 && (sb.size() != 0 || out_valid); i++)
            @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
